// File: rtl/aes128_cbc_dec_stream_ctrl.sv
// Purpose: sequences a 32-bit ciphertext stream into 128-bit CBC blocks for the AES core and replays the plaintext as 32-bit words.
// Latency: DEC_LATENCY cycles from the 4th accepted ciphertext word to pt_valid.
// Backpressure: one block in flight; ct_ready is low through WAIT and EMIT, and pt_word holds while pt_ready is low.
module aes128_cbc_dec_stream_ctrl #(
    parameter int DEC_LATENCY = 11,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      vector_in_0,
    input  logic [31:0]      vector_in_1,
    input  logic [31:0]      vector_in_2,
    input  logic [31:0]      vector_in_3,
    input  logic             iv_load,
    input  logic [31:0]      ct_word,
    input  logic             ct_valid,
    output logic             ct_ready,
    output logic [31:0]      pt_word,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [31:0]      cipher_text_0,
    output logic [31:0]      cipher_text_1,
    output logic [31:0]      cipher_text_2,
    output logic [31:0]      cipher_text_3,
    output logic [31:0]      vector_0,
    output logic [31:0]      vector_1,
    output logic [31:0]      vector_2,
    output logic [31:0]      vector_3,
    input  logic [31:0]      decrypted_plain_text_0,
    input  logic [31:0]      decrypted_plain_text_1,
    input  logic [31:0]      decrypted_plain_text_2,
    input  logic [31:0]      decrypted_plain_text_3,
    output logic             busy,
    output logic [CNT_W-1:0] block_count
);

    localparam int LAT_W = $clog2(DEC_LATENCY + 1);

    typedef enum logic [1:0] {COLLECT, WAIT, EMIT} state_t;

    state_t                 state;
    logic [1:0]             word_cnt;
    logic [LAT_W-1:0]       lat_cnt;
    logic [3:0][31:0]       chain_q;
    logic [3:0][31:0]       ct_q;
    logic [3:0][31:0]       pt_q;

    assign ct_ready      = (state == COLLECT) && !reset;
    assign pt_word       = pt_q[word_cnt];
    assign cipher_text_0 = ct_q[0];
    assign cipher_text_1 = ct_q[1];
    assign cipher_text_2 = ct_q[2];
    assign cipher_text_3 = ct_q[3];
    assign vector_0      = chain_q[0];
    assign vector_1      = chain_q[1];
    assign vector_2      = chain_q[2];
    assign vector_3      = chain_q[3];

    // word_cnt indexes ciphertext words in COLLECT and plaintext words in EMIT
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= COLLECT;
            word_cnt    <= 2'd0;
            lat_cnt     <= '0;
            chain_q     <= '0;
            ct_q        <= '0;
            pt_q        <= '0;
            block_count <= '0;
            pt_valid    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (iv_load && word_cnt == 2'd0)
                        chain_q <= {vector_in_3, vector_in_2, vector_in_1, vector_in_0};
                    if (ct_valid) begin
                        ct_q[word_cnt] <= ct_word;
                        word_cnt       <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            state   <= WAIT;
                            busy    <= 1'b1;
                            lat_cnt <= LAT_W'(DEC_LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        pt_q        <= {decrypted_plain_text_3, decrypted_plain_text_2,
                                        decrypted_plain_text_1, decrypted_plain_text_0};
                        chain_q     <= ct_q;
                        block_count <= block_count + CNT_W'(1);
                        pt_valid    <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                EMIT: begin
                    if (pt_ready) begin
                        word_cnt <= word_cnt + 2'd1;
                        if (word_cnt == 2'd3) begin
                            state    <= COLLECT;
                            pt_valid <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cbc_dec_stream_ctrl.sv
// Directed bench for the CBC stream sequencer with an XOR stub core (pt = ct ^ vector, DEC_LATENCY cycles).
module tb_aes128_cbc_dec_stream_ctrl;

    localparam int DL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] vector_in_0, vector_in_1, vector_in_2, vector_in_3;
    logic        iv_load;
    logic [31:0] ct_word;
    logic        ct_valid, ct_ready;
    logic [31:0] pt_word;
    logic        pt_valid, pt_ready;
    logic [31:0] cipher_text_0, cipher_text_1, cipher_text_2, cipher_text_3;
    logic [31:0] vector_0, vector_1, vector_2, vector_3;
    logic [31:0] decrypted_plain_text_0, decrypted_plain_text_1;
    logic [31:0] decrypted_plain_text_2, decrypted_plain_text_3;
    logic        busy;
    logic [15:0] block_count;

    aes128_cbc_dec_stream_ctrl #(.DEC_LATENCY(DL), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .vector_in_0(vector_in_0), .vector_in_1(vector_in_1),
        .vector_in_2(vector_in_2), .vector_in_3(vector_in_3),
        .iv_load(iv_load), .ct_word(ct_word), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .pt_word(pt_word), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .cipher_text_0(cipher_text_0), .cipher_text_1(cipher_text_1),
        .cipher_text_2(cipher_text_2), .cipher_text_3(cipher_text_3),
        .vector_0(vector_0), .vector_1(vector_1), .vector_2(vector_2), .vector_3(vector_3),
        .decrypted_plain_text_0(decrypted_plain_text_0), .decrypted_plain_text_1(decrypted_plain_text_1),
        .decrypted_plain_text_2(decrypted_plain_text_2), .decrypted_plain_text_3(decrypted_plain_text_3),
        .busy(busy), .block_count(block_count)
    );

    always #5 clk = ~clk;

    // Stub core: DL-1 register stages; the capture edge adds the last cycle of latency
    logic [127:0] sp0, sp1;
    always @(posedge clk) begin
        sp0 <= {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0} ^
               {vector_3, vector_2, vector_1, vector_0};
        sp1 <= sp0;
    end
    assign {decrypted_plain_text_3, decrypted_plain_text_2,
            decrypted_plain_text_1, decrypted_plain_text_0} = sp1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic ivl, input logic [127:0] iv);
        int t = 0;
        bit done = 0;
        @(negedge clk);
        ct_word = w; ct_valid = 1'b1; iv_load = ivl;
        {vector_in_3, vector_in_2, vector_in_1, vector_in_0} = iv;
        while (!done && t < 50) begin
            #1;
            if (ct_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
                t++;
            end
        end
        #1;
        acc_cyc = cyc;
        ct_valid = 1'b0; iv_load = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic wait_pt_valid(input bit check_lat);
        int t = 0;
        @(negedge clk);
        while (!pt_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!pt_valid) check("pt_valid_timeout", 0, 1);
        else if (check_lat) check("latency", 128'(cyc - acc_cyc), 128'(DL));
    endtask

    task automatic recv_word(input logic [31:0] exp);
        int t = 0;
        @(negedge clk);
        pt_ready = 1'b1;
        #1;
        while (!pt_valid && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("pt_word", pt_word, exp);
        @(posedge clk);
        #1;
        pt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ct_ready_in_reset", ct_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pt_valid", pt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_block_count", block_count, 0);
        check("rst_cipher_text", {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0}, 0);
        check("rst_vector", {vector_3, vector_2, vector_1, vector_0}, 0);
        check("rst_pt_word", pt_word, 0);
        check("rst_ct_ready", ct_ready, 1);
    endtask

    typedef struct {
        logic [3:0][31:0] ct;
        logic [3:0]       ivl;
        logic [127:0]     iv;
        bit               stall;
        logic [3:0][31:0] pt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        reset = 1'b1; iv_load = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0; ct_word = '0;
        {vector_in_3, vector_in_2, vector_in_1, vector_in_0} = '0;

        vecs[0] = '{ct: {32'd4, 32'd3, 32'd2, 32'd1}, ivl: 4'b0001, iv: '0, stall: 0,
                    pt: {32'd4, 32'd3, 32'd2, 32'd1}};
        vecs[1] = '{ct: {32'd8, 32'd7, 32'd6, 32'd5}, ivl: 4'b0000, iv: '0, stall: 1,
                    pt: {32'd12, 32'd4, 32'd4, 32'd4}};
        vecs[2] = '{ct: {32'h400, 32'h300, 32'h200, 32'h100}, ivl: 4'b0010, iv: {4{32'hAAAAAAAA}},
                    stall: 0, pt: {32'h408, 32'h307, 32'h206, 32'h105}};
        vecs[3] = '{ct: {32'd4, 32'd3, 32'd2, 32'd1}, ivl: 4'b0001, iv: {4{32'hAAAAAAAA}}, stall: 0,
                    pt: {32'hAAAAAAAE, 32'hAAAAAAA9, 32'hAAAAAAA8, 32'hAAAAAAAB}};
        vecs[4] = '{ct: {32'h40, 32'h30, 32'h20, 32'h10}, ivl: 4'b0000, iv: '0, stall: 0,
                    pt: {32'h44, 32'h33, 32'h22, 32'h11}};

        @(negedge clk);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) send_word(vecs[i].ct[k], vecs[i].ivl[k], vecs[i].iv);
            @(negedge clk);
            check("busy_in_wait", busy, 1);
            check("ct_ready_in_wait", ct_ready, 0);
            if (pt_valid) check("early_pt_valid", pt_valid, 0);
            wait_pt_valid(1);
            check("block_count", block_count, 128'(i + 1));
            if (vecs[i].stall) begin
                for (int s = 0; s < 5; s++) begin
                    check("stall_pt_word", pt_word, vecs[i].pt[0]);
                    check("stall_pt_valid", pt_valid, 1);
                    check("stall_ct_ready", ct_ready, 0);
                    @(negedge clk);
                end
            end
            for (int k = 0; k < 4; k++) recv_word(vecs[i].pt[k]);
            @(negedge clk);
            check("pt_valid_after_emit", pt_valid, 0);
            check("ct_ready_after_emit", ct_ready, 1);
        end

        // Reset with a partial block collected
        send_word(32'h11, 1'b1, {4{32'h55555555}});
        send_word(32'h22, 1'b0, '0);
        do_reset();
        for (int k = 0; k < 4; k++) send_word(32'(k + 1), 1'b0, '0);
        wait_pt_valid(1);
        check("block_count_after_rst", block_count, 1);
        for (int k = 0; k < 4; k++) recv_word(32'(k + 1));

        // Reset while waiting on the core
        for (int k = 0; k < 4; k++) send_word(32'h77, 1'b0, '0);
        do_reset();
        for (int k = 0; k < 4; k++) send_word(32'h700 + 32'(k), 1'b0, '0);
        wait_pt_valid(1);
        for (int k = 0; k < 4; k++) recv_word(32'h700 + 32'(k));

        // Reset partway through plaintext replay
        for (int k = 0; k < 4; k++) send_word(32'h900 + 32'(k), 1'b0, '0);
        wait_pt_valid(1);
        recv_word(32'h900 ^ 32'h700);
        do_reset();
        for (int k = 0; k < 4; k++) send_word(32'hC0 + 32'(k), 1'b0, '0);
        wait_pt_valid(1);
        for (int k = 0; k < 4; k++) recv_word(32'hC0 + 32'(k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
